mul_operand_sequencer: RTL

- Front-end and back-end for the repeated-addition multiplier (16-bit datapath plus controller).
- Accepts an operand pair on a valid/ready interface and drives the multiplier's shared data bus and start line in the required A-then-B order.
- Waits for the multiplier's done, captures the 16-bit product and presents it on a valid/ready result interface.
- Clears the multiplier between jobs and guards against a hung multiplier with a timeout.

---
 rtl/mul_operand_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Front-end and back-end for the repeated-addition multiplier. Accepts an
//   operand pair on a valid/ready interface and feeds the multiplier's shared
//   data bus in the order it expects: a start pulse carrying A, an A-load
//   cycle, then a B-load cycle. It then waits for done, captures the product,
//   clears the multiplier and presents the result on a valid/ready interface.
//   A cycle counter aborts a job whose done never arrives.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   in_a, in_b            multiplicand and multiplier (repeat count)
//   mul_start             one-cycle start pulse to the multiplier controller
//   mul_data              multiplier data_in bus (A, A, B, then B while waiting)
//   mul_clr               one-cycle clear back to the multiplier's idle state
//   mul_done, mul_product multiplier done level and product register
//   out_valid/out_ready   result handshake
//   out_product           captured product (0 on timeout or zero bypass)
//   out_timeout           1 when the job aborted on the cycle limit
//   busy                  high in every state except IDLE
//
// All outputs are registered: each one is loaded on the edge that enters the
// state in which it must hold, so the bus sequence lines up with the state
// the multiplier is in on that same cycle.

module mul_operand_sequencer #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT     = 70000,
  parameter int ZERO_BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_data,
  output logic             mul_clr,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    CLEAR,
    RESULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] wait_cnt;

  // A zero operand makes the product trivially zero, so the multiplier is
  // skipped entirely when bypass is enabled.
  logic zero_op;
  assign zero_op = (ZERO_BYPASS != 0) && ((in_a == '0) || (in_b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      wait_cnt    <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      mul_start   <= 1'b0;
      mul_clr     <= 1'b0;
      mul_data    <= '0;
      out_product <= '0;
      out_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              out_product <= '0;
              out_timeout <= 1'b0;
              out_valid   <= 1'b1;
              state       <= RESULT;
            end else begin
              // The start cycle already carries A on the bus.
              mul_start <= 1'b1;
              mul_data  <= in_a;
              state     <= START;
            end
          end
        end

        START: begin
          mul_start <= 1'b0;
          mul_data  <= a_r;
          state     <= LOAD_A;
        end

        LOAD_A: begin
          mul_data <= b_r;
          state    <= LOAD_B;
        end

        LOAD_B: begin
          // Counter starts from zero on the first WAIT cycle.
          mul_data <= b_r;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          // Done is checked first so it wins over a simultaneous timeout.
          if (mul_done) begin
            out_product <= mul_product;
            out_timeout <= 1'b0;
            mul_clr     <= 1'b1;
            mul_data    <= '0;
            state       <= CLEAR;
          end else if (wait_cnt == CNT_LAST) begin
            out_product <= '0;
            out_timeout <= 1'b1;
            mul_clr     <= 1'b1;
            mul_data    <= '0;
            state       <= CLEAR;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        CLEAR: begin
          mul_clr   <= 1'b0;
          out_valid <= 1'b1;
          state     <= RESULT;
        end

        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          mul_start <= 1'b0;
          mul_clr   <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
